// File: rtl/alu_insn_sequencer_if.sv
// alu_insn_sequencer_if: control-unit <-> DataPath bundle (run/ir/mem_ready in, strobes and status out).
// Carries the step input only when SINGLE_STEP_EN is defined.
interface alu_insn_sequencer_if #(parameter int NREGS = 16, parameter int ALU_W = 8);
    logic run, mem_ready;
    logic [31:0] ir;
`ifdef SINGLE_STEP_EN
    logic step;
`endif
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [NREGS-1:0] Rin, Rout;
    logic [ALU_W-1:0] ALU_control;
    logic busy, halted, illegal;
    modport master (
`ifdef SINGLE_STEP_EN
        input step,
`endif
        input run, mem_ready, ir,
        output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, Yin, HIin, LOin,
        output Rin, Rout, ALU_control, busy, halted, illegal
    );
    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output run, mem_ready, ir,
        input PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, Yin, HIin, LOin,
        input Rin, Rout, ALU_control, busy, halted, illegal
    );
endinterface

// File: rtl/alu_insn_sequencer.sv
// alu_insn_sequencer: hardwired fetch (T0-T2) and reg-reg ALU execute (T3-T6) control unit for the DataPath.
// SINGLE_STEP_EN gates every transition out of T0-T6 on bus.step.
module alu_insn_sequencer #(
    parameter int NREGS = 16,
    parameter int ALU_W = 8
) (
    input logic clock,
    input logic clear,
    alu_insn_sequencer_if.master bus
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED} state_t;
    state_t r_state;
    logic r_illegal;
    logic [4:0] w_op;
    logic w_bin, w_una, w_muldiv, w_nop, w_halt, w_go, w_unused;
    state_t w_next;
    function automatic logic [NREGS-1:0] onehot(input logic [3:0] f);
        return NREGS'(1) << (int'(f) % NREGS);
    endfunction
    assign w_op = bus.ir[31:27];
    assign w_muldiv = w_op == 5'd15 || w_op == 5'd16;
    assign w_bin = (w_op >= 5'd3 && w_op <= 5'd11) || w_muldiv;
    assign w_una = w_op == 5'd17 || w_op == 5'd18;
    assign w_nop = w_op == 5'd26;
    assign w_halt = w_op == 5'd27;
    assign w_next = bus.run ? T0 : IDLE;
    assign w_unused = ^bus.ir[14:0];
`ifdef SINGLE_STEP_EN
    assign w_go = bus.step;
`else
    assign w_go = 1'b1;
`endif
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.run) r_state <= T0;
                T0: if (w_go) r_state <= T1;
                T1: if (w_go && bus.mem_ready) r_state <= T2;
                T2: if (w_go) r_state <= T3;
                T3: if (w_go) begin
                    if (w_bin || w_una) r_state <= T4;
                    else if (w_halt) r_state <= HALTED;
                    else begin
                        r_state <= w_next;
                        r_illegal <= r_illegal | !w_nop;
                    end
                end
                T4: if (w_go) r_state <= T5;
                T5: if (w_go) r_state <= w_muldiv ? T6 : w_next;
                T6: if (w_go) r_state <= w_next;
                HALTED: r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.PCout = r_state == T0;
    assign bus.MARin = r_state == T0;
    assign bus.IncPC = r_state == T0;
    assign bus.Zin = r_state == T0 || r_state == T4;
    assign bus.Zlowout = r_state == T1 || r_state == T5;
    assign bus.PCin = r_state == T1;
    assign bus.read = r_state == T1;
    assign bus.MDRin = r_state == T1;
    assign bus.MDRout = r_state == T2;
    assign bus.IRin = r_state == T2;
    assign bus.Yin = r_state == T3 && w_bin;
    assign bus.Zhighout = r_state == T6;
    assign bus.HIin = r_state == T6;
    assign bus.LOin = r_state == T5 && w_muldiv;
    assign bus.Rin = (r_state == T5 && !w_muldiv) ? onehot(bus.ir[26:23]) : '0;
    // binary ops put Rb on the bus into Y first, then Rc into the ALU; unary ops only use Rb
    assign bus.Rout = (r_state == T3 && w_bin) ? onehot(bus.ir[22:19]) :
                      (r_state == T4) ? onehot(w_bin ? bus.ir[18:15] : bus.ir[22:19]) : '0;
    assign bus.ALU_control = (r_state == T4) ? ALU_W'({3'b000, w_op}) : '0;
    assign bus.busy = r_state != IDLE && r_state != HALTED;
    assign bus.halted = r_state == HALTED;
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_alu_insn_sequencer.sv
// tb_alu_insn_sequencer: randomized instruction stream checked cycle-by-cycle against a per-opcode strobe schedule.
module tb_alu_insn_sequencer;
    localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800, S_ZIN = 14'h0400,
                            S_ZLO = 14'h0200, S_ZHI = 14'h0100, S_PCIN = 14'h0080, S_READ = 14'h0040,
                            S_MDRIN = 14'h0020, S_MDROUT = 14'h0010, S_IRIN = 14'h0008, S_YIN = 14'h0004,
                            S_HIIN = 14'h0002, S_LOIN = 14'h0001;
    typedef struct {
        logic [55:0] v;
        int mr;
        string tag;
    } step_t;
    logic clock, clear;
    logic ill;
    int n_chk, n_err;
    alu_insn_sequencer_if #(.NREGS(16), .ALU_W(8)) bus ();
    alu_insn_sequencer #(.NREGS(16), .ALU_W(8)) dut (.clock(clock), .clear(clear), .bus(bus));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [56:0] got, input logic [56:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [56:0] obs();
        return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.Zhighout, bus.PCin, bus.read,
                bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.HIin, bus.LOin,
                bus.Rin, bus.Rout, bus.ALU_control, bus.busy, bus.halted, bus.illegal};
    endfunction
    function automatic logic [55:0] e(input logic [13:0] s, input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [7:0] alu);
        return {s, rin, rout, alu, 1'b1, 1'b0};
    endfunction
    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask
    task automatic rand_step;
`ifdef SINGLE_STEP_EN
        bus.step = 1'($urandom);
`endif
    endtask
    task automatic idle_then_start(input string tag);
        check(tag, obs(), {56'd0, ill});
        rand_step();
        bus.run = 1'b1;
        tick();
    endtask
    task automatic play(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                        input int waits, input logic run_next, input int clr_at);
        step_t q[$];
        logic bin, una, md;
        int hold;
        md = op inside {5'd15, 5'd16};
        bin = md || op inside {[5'd3:5'd11]};
        una = op inside {5'd17, 5'd18};
        bus.ir = {op, ra, rb, rc, 15'($urandom)};
        q.push_back('{e(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0), -1, "T0"});
        for (int w = 0; w < waits; w++) q.push_back('{e(S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 0, 0), 0, "T1wait"});
        q.push_back('{e(S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 0, 0), 1, "T1"});
        q.push_back('{e(S_MDROUT | S_IRIN, 0, 0, 0), -1, "T2"});
        q.push_back('{e(bin ? S_YIN : 14'd0, 0, bin ? 16'd1 << rb : 16'd0, 0), -1, "T3"});
        if (bin || una) begin
            q.push_back('{e(S_ZIN, 0, 16'd1 << (bin ? rc : rb), {3'b000, op}), -1, "T4"});
            q.push_back('{md ? e(S_ZLO | S_LOIN, 0, 0, 0) : e(S_ZLO, 16'd1 << ra, 0, 0), -1, "T5"});
            if (md) q.push_back('{e(S_ZHI | S_HIIN, 0, 0, 0), -1, "T6"});
        end
        foreach (q[i]) begin
            if (i == clr_at) begin
                check({q[i].tag, "_preclr"}, obs(), {q[i].v, ill});
                clear = 1'b1;
                bus.run = 1'($urandom);
                tick();
                clear = 1'b0;
                ill = 1'b0;
                idle_then_start("clr_idle");
                return;
            end
            hold = 0;
`ifdef SINGLE_STEP_EN
            hold = (q[i].tag == "T3") ? 5 : $urandom_range(0, 2);
`endif
            for (int h = 0; h <= hold; h++) begin
                check(q[i].tag, obs(), {q[i].v, ill});
`ifdef SINGLE_STEP_EN
                bus.step = (h == hold);
`endif
                bus.mem_ready = (h < hold || q[i].mr < 0) ? 1'($urandom) : q[i].mr[0];
                bus.run = (h == hold && i == q.size() - 1) ? run_next : 1'($urandom);
                tick();
            end
        end
        if (op == 5'd27) begin
            repeat (4) begin
                check("halted", obs(), {54'd0, 1'b0, 1'b1, ill});
                rand_step();
                bus.run = 1'($urandom);
                bus.mem_ready = 1'($urandom);
                tick();
            end
            clear = 1'b1;
            tick();
            clear = 1'b0;
            ill = 1'b0;
            idle_then_start("halt_clr_idle");
            return;
        end
        if (!(bin || una || op == 5'd26)) ill = 1'b1;
        if (!run_next) begin
            check("idle_hold", obs(), {56'd0, ill});
            bus.run = 1'b0;
            rand_step();
            tick();
            idle_then_start("idle");
        end
    endtask
    initial begin
        n_chk = 0;
        n_err = 0;
        ill = 1'b0;
        clear = 1'b1;
        bus.run = 1'b1;
        bus.mem_ready = 1'b1;
        bus.ir = 32'd0;
`ifdef SINGLE_STEP_EN
        bus.step = 1'b1;
`endif
        repeat (2) tick();
        check("reset", obs(), 57'd0);
        clear = 1'b0;
        bus.run = 1'b0;
        tick();
        idle_then_start("idle_start");
        play(5'd7, 4'd4, 4'd3, 4'd5, 0, 1'b1, -1);
        play(5'd7, 4'd4, 4'd3, 4'd5, 3, 1'b1, -1);
        play(5'd15, 4'd1, 4'd2, 4'd6, 0, 1'b1, -1);
        play(5'd16, 4'd9, 4'd14, 4'd0, 1, 1'b1, -1);
        play(5'd18, 4'd7, 4'd12, 4'd1, 0, 1'b1, -1);
        play(5'd31, 4'd1, 4'd2, 4'd3, 0, 1'b1, -1);
        play(5'd26, 4'd0, 4'd0, 4'd0, 2, 1'b0, -1);
        play(5'd3, 4'd15, 4'd8, 4'd11, 0, 1'b1, 4);
        play(5'd11, 4'd2, 4'd10, 4'd13, 0, 1'b0, -1);
        play(5'd27, 4'd0, 4'd0, 4'd0, 0, 1'b1, -1);
        for (int k = 0; k < 80; k++)
            play(5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
